// File: rtl/encode_pending_scan_if.sv
// Request/presentation bundle for encode_pending_scan: the request side drives
// en/x/flush/ready, the encoder returns valid/y/pending/drop_cnt.
interface encode_pending_scan_if #(
    parameter int N  = 16,
    parameter int W  = 4,
    parameter int CW = 8
);
    logic          en;
    logic [N-1:0]  x;
    logic          flush;
    logic          ready;
    logic          valid;
    logic [W-1:0]  y;
    logic [N-1:0]  pending;
    logic [CW-1:0] drop_cnt;

    modport master (
        output en, x, flush, ready,
        input  valid, y, pending, drop_cnt
    );

    modport slave (
        input  en, x, flush, ready,
        output valid, y, pending, drop_cnt
    );
endinterface

// File: rtl/encode_pending_scan.sv
// Pending-request encoder: latches request lines and presents one index per cycle
// on a valid/ready handshake, fixed priority (RR=0) or round-robin from ptr (RR=1).
module encode_pending_scan #(
    parameter int N  = 16,
    parameter int W  = 4,
    parameter int RR = 0,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    encode_pending_scan_if.slave bus
);
    localparam logic [N-1:0]  ONE     = N'(1);
    localparam logic [W-1:0]  LAST    = W'(N - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [N-1:0]  pend_q, pend_d;
    logic [W-1:0]  y_q, y_d;
    logic          v_q, v_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          acc;
    logic [N-1:0]  clr, req, pend_n;
    logic [W-1:0]  ptr_n;
    logic          coal;

    // Lowest set index overall; in RR mode an index at or above base takes precedence.
    function automatic logic [W-1:0] sel(input logic [N-1:0] p, input logic [W-1:0] base);
        logic [W-1:0] idx;
        logic         hit;
        idx = '0;
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (p[i]) idx = W'(i);
        end
        if (RR != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (p[i] && (i >= int'(base))) begin
                    idx = W'(i);
                    hit = 1'b1;
                end
            end
            if (!hit) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (p[i]) idx = W'(i);
                end
            end
        end
        return idx;
    endfunction

    always_comb begin
        acc    = v_q & bus.ready;
        clr    = acc ? (ONE << y_q) : '0;
        req    = bus.en ? bus.x : '0;
        pend_n = (pend_q & ~clr) | req;
        ptr_n  = ((RR != 0) && acc) ? ((y_q == LAST) ? '0 : y_q + W'(1)) : ptr_q;
        coal   = |(req & pend_q & ~clr);

        pend_d = pend_q;
        y_d    = y_q;
        v_d    = v_q;
        ptr_d  = ptr_q;
        drop_d = drop_q;

        if (bus.flush) begin
            // flush drops everything pending but keeps ptr and the drop history
            pend_d = '0;
            y_d    = '0;
            v_d    = 1'b0;
        end else begin
            pend_d = pend_n;
            ptr_d  = ptr_n;
            if (coal && (drop_q != CNT_MAX)) drop_d = drop_q + CW'(1);
            // a presented index is frozen until the consumer takes it
            if (!v_q || acc) begin
                v_d = |pend_n;
                y_d = sel(pend_n, ptr_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            y_q    <= '0;
            v_q    <= 1'b0;
            ptr_q  <= '0;
            drop_q <= '0;
        end else begin
            pend_q <= pend_d;
            y_q    <= y_d;
            v_q    <= v_d;
            ptr_q  <= ptr_d;
            drop_q <= drop_d;
        end
    end

    assign bus.valid    = v_q;
    assign bus.y        = y_q;
    assign bus.pending  = pend_q;
    assign bus.drop_cnt = drop_q;
endmodule
